// File: rtl/ycr_sleep_pkg.sv
// Shared definitions for the core-side sleep handshake: FSM state encoding
// and the default drain timeout.
package ycr_sleep_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_WAKE   = 2'd3
    } sleep_state_e;

    localparam int DRAIN_TMO_DEF = 200;

endpackage

// File: rtl/ycr_outst_cnt.sv
// Outstanding-transaction tracker: saturating up/down counter with a zero flag.
module ycr_outst_cnt #(
    parameter int OUTST_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero
);

    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    logic [OUTST_W-1:0] cnt;

    // A request and a response in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ycr_core_sleep_ctrl.sv
// Core-side WFI sleep handshake: drains imem/dmem traffic, requests sleep
// from the clock-gate controller and stalls the core until wakeup.
module ycr_core_sleep_ctrl
    import ycr_sleep_pkg::*;
#(
    parameter int OUTST_W   = 3,
    parameter int TMO_W     = 8,
    parameter int DRAIN_TMO = DRAIN_TMO_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_sleep_en,
    input  logic       wfi_req_i,
    input  logic       irq_pend_i,
    input  logic       imem_req_i,
    input  logic       imem_resp_i,
    input  logic       dmem_req_i,
    input  logic       dmem_resp_i,
    input  logic       wakeup_i,
    output logic       sleep_o,
    output logic       core_stall_o,
    output logic       wfi_done_o,
    output logic       aborted_o,
    output logic [1:0] state_o
);

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(DRAIN_TMO);

    sleep_state_e     state;
    sleep_state_e     state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             imem_zero;
    logic             dmem_zero;
    logic             drained;
    logic             tmo_hit;
    logic             done_nxt;
    logic             abort_nxt;
    logic [3:0]       proto_err_cnt;

    ycr_outst_cnt #(.OUTST_W(OUTST_W)) u_imem_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (imem_req_i),
        .dec  (imem_resp_i),
        .zero (imem_zero)
    );

    ycr_outst_cnt #(.OUTST_W(OUTST_W)) u_dmem_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (dmem_req_i),
        .dec  (dmem_resp_i),
        .zero (dmem_zero)
    );

    assign drained = imem_zero && dmem_zero && !imem_req_i && !dmem_req_i;
    assign tmo_hit = (tmo_cnt == TMO_LIM);

    // The abort pulse is raised one cycle ahead so it coincides with the
    // final drain cycle; the following cycle then leaves DRAIN unconditionally.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (wfi_req_i) begin
                    if (!cfg_sleep_en || irq_pend_i) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (tmo_hit || irq_pend_i) begin
                    state_nxt = ST_WAKE;
                end else if (drained) begin
                    state_nxt = ST_SLEEP;
                end else if (tmo_cnt == TMO_LIM - 1'b1) begin
                    abort_nxt = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (wakeup_i || irq_pend_i) begin
                    state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                state_nxt = ST_ACTIVE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_ACTIVE;
            tmo_cnt       <= '0;
            sleep_o       <= 1'b0;
            core_stall_o  <= 1'b0;
            wfi_done_o    <= 1'b0;
            aborted_o     <= 1'b0;
            proto_err_cnt <= '0;
        end else begin
            state        <= state_nxt;
            sleep_o      <= (state_nxt == ST_SLEEP);
            core_stall_o <= (state_nxt != ST_ACTIVE);
            wfi_done_o   <= done_nxt;
            aborted_o    <= abort_nxt;
            tmo_cnt      <= (state == ST_DRAIN) ? tmo_cnt + 1'b1 : '0;
            // Traffic while the core should be asleep is a protocol error.
            if (state == ST_SLEEP && (imem_req_i || dmem_req_i) && proto_err_cnt != '1) begin
                proto_err_cnt <= proto_err_cnt + 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_ycr_core_sleep_ctrl.sv
// Scoreboard bench for ycr_core_sleep_ctrl: directed handshake scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_ycr_core_sleep_ctrl;

    localparam int OUTST_W   = 3;
    localparam int TMO_W     = 8;
    localparam int DRAIN_TMO = 200;
    localparam int CNT_MAX   = (1 << OUTST_W) - 1;
    localparam int PH_ACTIVE = 0;
    localparam int PH_DRAIN  = 1;
    localparam int PH_SLEEP  = 2;
    localparam int PH_WAKE   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_sleep_en = 1'b0;
    logic       wfi_req_i = 1'b0;
    logic       irq_pend_i = 1'b0;
    logic       imem_req_i = 1'b0;
    logic       imem_resp_i = 1'b0;
    logic       dmem_req_i = 1'b0;
    logic       dmem_resp_i = 1'b0;
    logic       wakeup_i = 1'b0;
    logic       sleep_o;
    logic       core_stall_o;
    logic       wfi_done_o;
    logic       aborted_o;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    ycr_core_sleep_ctrl #(
        .OUTST_W   (OUTST_W),
        .TMO_W     (TMO_W),
        .DRAIN_TMO (DRAIN_TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_sleep_en (cfg_sleep_en),
        .wfi_req_i    (wfi_req_i),
        .irq_pend_i   (irq_pend_i),
        .imem_req_i   (imem_req_i),
        .imem_resp_i  (imem_resp_i),
        .dmem_req_i   (dmem_req_i),
        .dmem_resp_i  (dmem_resp_i),
        .wakeup_i     (wakeup_i),
        .sleep_o      (sleep_o),
        .core_stall_o (core_stall_o),
        .wfi_done_o   (wfi_done_o),
        .aborted_o    (aborted_o),
        .state_o      (state_o)
    );

    typedef struct packed {
        logic       sleep;
        logic       stall;
        logic       done;
        logic       abort;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_sleep_rise = -1;
    int   last_sleep_fall = -1;
    int   last_stall_fall = -1;
    int   last_done = -1;
    int   last_abort = -1;
    logic prev_sleep = 1'b0;
    logic prev_stall = 1'b0;
    logic sleep_seen = 1'b0;
    logic stall_seen = 1'b0;
    logic irq_lvl = 1'b0;
    logic cfg_lvl = 1'b1;

    // Reference model: phase of the handshake, outstanding counts and drain age.
    int m_phase = PH_ACTIVE;
    int m_imem = 0;
    int m_dmem = 0;
    int m_age = 0;

    function automatic void check(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, expv);
        end
    endfunction

    function automatic void model_reset();
        m_phase = PH_ACTIVE;
        m_imem  = 0;
        m_dmem  = 0;
        m_age   = 0;
    endfunction

    function automatic int track(int n, logic req, logic resp);
        if (req && !resp) return (n < CNT_MAX) ? n + 1 : CNT_MAX;
        if (resp && !req) return (n > 0) ? n - 1 : 0;
        return n;
    endfunction

    // Predicts what the DUT shows after the edge that samples the current inputs.
    function automatic void model_step();
        exp_t e;
        int   nxt = m_phase;
        logic done = 1'b0;
        logic ab = 1'b0;
        logic quiet = (m_imem == 0) && (m_dmem == 0) && !imem_req_i && !dmem_req_i;
        if (m_phase == PH_ACTIVE) begin
            if (wfi_req_i) begin
                if (!cfg_sleep_en || irq_pend_i) done = 1'b1;
                else nxt = PH_DRAIN;
            end
        end else if (m_phase == PH_DRAIN) begin
            if (m_age == DRAIN_TMO || irq_pend_i) nxt = PH_WAKE;
            else if (quiet) nxt = PH_SLEEP;
            else if (m_age + 1 == DRAIN_TMO) ab = 1'b1;
        end else if (m_phase == PH_SLEEP) begin
            if (wakeup_i || irq_pend_i) nxt = PH_WAKE;
        end else begin
            nxt  = PH_ACTIVE;
            done = 1'b1;
        end
        m_age   = (m_phase == PH_DRAIN) ? m_age + 1 : 0;
        m_imem  = track(m_imem, imem_req_i, imem_resp_i);
        m_dmem  = track(m_dmem, dmem_req_i, dmem_resp_i);
        m_phase = nxt;
        e.sleep = (nxt == PH_SLEEP);
        e.stall = (nxt != PH_ACTIVE);
        e.done  = done;
        e.abort = ab;
        e.st    = 2'(nxt);
        exp_q.push_back(e);
    endfunction

    task automatic drive(input logic w, input logic ir, input logic irs,
                         input logic dr, input logic drs, input logic wk);
        @(negedge clk);
        cfg_sleep_en = cfg_lvl;
        irq_pend_i   = irq_lvl;
        wfi_req_i    = w;
        imem_req_i   = ir;
        imem_resp_i  = irs;
        dmem_req_i   = dr;
        dmem_resp_i  = drs;
        wakeup_i     = wk;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_sleep_scenario(input string tag);
        int w;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        w = cyc;
        idle(9);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);
        check({tag, "_sleep_rise"}, last_sleep_rise - w, 2);
        check({tag, "_sleep_fall"}, last_sleep_fall - w, 11);
        check({tag, "_stall_fall"}, last_stall_fall - w, 12);
        check({tag, "_wfi_done"}, last_done - w, 12);
    endtask

    // Monitor: samples just after each active edge and retires one prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (sleep_o && !prev_sleep) last_sleep_rise = cyc;
        if (!sleep_o && prev_sleep) last_sleep_fall = cyc;
        if (!core_stall_o && prev_stall) last_stall_fall = cyc;
        if (wfi_done_o) last_done = cyc;
        if (aborted_o) last_abort = cyc;
        if (sleep_o) sleep_seen = 1'b1;
        if (core_stall_o) stall_seen = 1'b1;
        prev_sleep = sleep_o;
        prev_stall = core_stall_o;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_sleep", sleep_o, e.sleep);
            check("sb_stall", core_stall_o, e.stall);
            check("sb_done", wfi_done_o, e.done);
            check("sb_abort", aborted_o, e.abort);
            check("sb_state", state_o, e.st);
        end
    end

    initial begin
        int w;
        repeat (2) @(negedge clk);
        check("rst_sleep", sleep_o, 0);
        check("rst_stall", core_stall_o, 0);
        check("rst_done", wfi_done_o, 0);
        check("rst_abort", aborted_o, 0);
        check("rst_state", state_o, 0);
        rst = 1'b0;
        model_reset();

        cfg_lvl = 1'b1;
        idle(2);
        idle_sleep_scenario("idle");

        // Two dmem requests still in flight when WFI retires.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        w = cyc;
        idle(4);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("drain_sleep_rise", last_sleep_rise - w, 9);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Pending interrupt, then sleep disabled: WFI is a NOP either way.
        for (int k = 0; k < 2; k++) begin
            irq_lvl = (k == 0);
            cfg_lvl = (k != 0) ? 1'b0 : 1'b1;
            idle(1);
            sleep_seen = 1'b0;
            stall_seen = 1'b0;
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            w = cyc;
            idle(3);
            check("bypass_done", last_done - w, 1);
            check("bypass_stall_seen", stall_seen, 0);
            check("bypass_sleep_seen", sleep_seen, 0);
        end
        irq_lvl = 1'b0;
        cfg_lvl = 1'b1;
        idle(2);

        // An imem request that is never answered forces the drain timeout.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sleep_seen = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        w = cyc;
        idle(206);
        check("tmo_abort", last_abort - w, DRAIN_TMO + 1);
        check("tmo_stall_fall", last_stall_fall - last_abort, 2);
        check("tmo_done", last_done - last_abort, 2);
        check("tmo_sleep_seen", sleep_seen, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Simultaneous req+resp must leave a count of two untouched.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        w = cyc;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("simul_sleep_rise", last_sleep_rise - w, 4);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Nine requests saturate at seven: exactly seven responses drain it.
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        w = cyc;
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("sat_sleep_rise", last_sleep_rise - w, 9);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Asynchronous reset while asleep.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        @(negedge clk);
        check("pre_rst_sleep", sleep_o, 1);
        rst = 1'b1;
        wfi_req_i = 1'b0;
        #1;
        check("arst_sleep", sleep_o, 0);
        check("arst_stall", core_stall_o, 0);
        check("arst_state", state_o, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(1);
        idle_sleep_scenario("post_rst");

        // Randomized traffic; no requests are issued while the model is asleep.
        for (int i = 0; i < 3000; i++) begin
            logic w_r, ir, irs, dr, drs, wk;
            if ($urandom_range(0, 19) == 0) irq_lvl = ~irq_lvl;
            if ($urandom_range(0, 49) == 0) cfg_lvl = ~cfg_lvl;
            w_r = ($urandom_range(0, 7) == 0);
            ir  = (m_phase != PH_SLEEP) && ($urandom_range(0, 3) == 0);
            dr  = (m_phase != PH_SLEEP) && ($urandom_range(0, 3) == 0);
            irs = ($urandom_range(0, 2) == 0);
            drs = ($urandom_range(0, 2) == 0);
            wk  = ($urandom_range(0, 5) == 0);
            drive(w_r, ir, irs, dr, drs, wk);
        end
        irq_lvl = 1'b0;
        idle(2);
        @(posedge clk);
        #2;
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
